// File: rtl/input_debounce_sync.sv
// Two-flop synchronizer plus per-channel stability counter for board switches and push-button.
// Clean levels and one-cycle change pulses are all registered; a new level appears DEBOUNCE_CYCLES+2 edges after the raw change.
module input_debounce_sync #(
  parameter int NUM_SW            = 8,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [NUM_SW-1:0] sw_raw,
  input  logic              button_raw,
  output logic [NUM_SW-1:0] switches_clean,
  output logic              button_clean,
  output logic              button_press,
  output logic              button_release,
  output logic [NUM_SW-1:0] sw_changed
);

  localparam int NCH = NUM_SW + 1;
  localparam int CW  = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Button occupies the top channel and is made active-high before synchronizing.
  logic [NCH-1:0] raw_ch;
  assign raw_ch = {button_raw ^ BUTTON_ACTIVE_LOW, sw_raw};

  logic [NCH-1:0]    s1_q;
  logic [NCH-1:0]    s2_q;
  logic [NCH-1:0]    stable_q;
  logic [NCH-1:0]    stable_d;
  logic [NCH-1:0]    accept_d;
  logic [CW-1:0]     cnt_q [NCH];
  logic [CW-1:0]     cnt_d [NCH];
  logic [NUM_SW-1:0] chg_q;
  logic              press_q;
  logic              release_q;

  always_comb begin
    stable_d = stable_q;
    accept_d = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          accept_d[i] = 1'b1;
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      chg_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= raw_ch;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      // Pulses land in the same cycle the new stable level becomes visible.
      chg_q     <= accept_d[NUM_SW-1:0];
      press_q   <= accept_d[NUM_SW] & s2_q[NUM_SW];
      release_q <= accept_d[NUM_SW] & ~s2_q[NUM_SW];
    end
  end

  assign switches_clean = stable_q[NUM_SW-1:0];
  assign button_clean   = stable_q[NUM_SW];
  assign button_press   = press_q;
  assign button_release = release_q;
  assign sw_changed     = chg_q;

endmodule

// File: tb/tb_input_debounce_sync.sv
// Randomized and directed bench for input_debounce_sync against a windowed-history reference model.
module tb_input_debounce_sync;

  localparam int NSW = 8;
  localparam int DC  = 4;
  localparam int NCH = NSW + 1;

  logic           clk_clk = 1'b0;
  logic           reset_reset = 1'b1;
  logic [NSW-1:0] sw_raw = '0;
  logic           button_raw = 1'b1;
  logic [NSW-1:0] switches_clean;
  logic           button_clean;
  logic           button_press;
  logic           button_release;
  logic [NSW-1:0] sw_changed;

  input_debounce_sync #(
    .NUM_SW(NSW),
    .DEBOUNCE_CYCLES(DC),
    .BUTTON_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .sw_raw(sw_raw),
    .button_raw(button_raw),
    .switches_clean(switches_clean),
    .button_clean(button_clean),
    .button_press(button_press),
    .button_release(button_release),
    .sw_changed(sw_changed)
  );

  always #5 clk_clk = ~clk_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a channel adopts a new level once the synchronized value seen
  // at the last DC edges (none of them under reset) all disagreed with the current level.
  logic [NCH-1:0] m_s1, m_s2, m_stable, m_chg;
  logic           m_press, m_rel;
  logic [NCH-1:0] hist [DC];
  logic           hist_ok [DC];

  task automatic model_step();
    logic all_diff;
    for (int k = DC - 1; k > 0; k--) begin
      hist[k]    = hist[k-1];
      hist_ok[k] = hist_ok[k-1];
    end
    hist[0]    = m_s2;
    hist_ok[0] = !reset_reset;
    if (reset_reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_chg = '0; m_press = 1'b0; m_rel = 1'b0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DC; k++)
          if (!hist_ok[k] || hist[k][ch] == m_stable[ch]) all_diff = 1'b0;
        m_chg[ch] = all_diff;
      end
      m_stable = m_stable ^ m_chg;
      m_press  = m_chg[NSW] & m_stable[NSW];
      m_rel    = m_chg[NSW] & ~m_stable[NSW];
      m_s2     = m_s1;
      m_s1     = {~button_raw, sw_raw};
    end
  endtask

  // Directed-scenario observations, counted in edges since clear_obs.
  int edge_i, first_btn, first_sw0, first_chg_edge, presses, releases, sw0_chg, btn_seen;
  logic [NSW-1:0] first_chg_val;

  task automatic clear_obs();
    edge_i = 0; first_btn = 0; first_sw0 = 0; first_chg_edge = 0;
    presses = 0; releases = 0; sw0_chg = 0; btn_seen = 0; first_chg_val = '0;
  endtask

  task automatic cyc(input logic rst, input logic btn, input logic [NSW-1:0] sw);
    @(negedge clk_clk);
    reset_reset = rst;
    button_raw  = btn;
    sw_raw      = sw;
    @(posedge clk_clk);
    model_step();
    #1;
    chk("sw_clean",   32'(switches_clean), 32'(m_stable[NSW-1:0]));
    chk("btn_clean",  32'(button_clean),   32'(m_stable[NSW]));
    chk("btn_press",  32'(button_press),   32'(m_press));
    chk("btn_rel",    32'(button_release), 32'(m_rel));
    chk("sw_changed", 32'(sw_changed),     32'(m_chg[NSW-1:0]));
    edge_i++;
    if (button_clean) btn_seen++;
    if (button_clean && first_btn == 0) first_btn = edge_i;
    if (switches_clean[0] && first_sw0 == 0) first_sw0 = edge_i;
    if (sw_changed != 0 && first_chg_edge == 0) begin
      first_chg_edge = edge_i;
      first_chg_val  = sw_changed;
    end
    if (button_press) presses++;
    if (button_release) releases++;
    if (sw_changed[0]) sw0_chg++;
  endtask

  task automatic hold(input int n, input logic rst, input logic btn, input logic [NSW-1:0] sw);
    for (int i = 0; i < n; i++) cyc(rst, btn, sw);
  endtask

  logic           r_btn;
  logic [NSW-1:0] r_sw;
  int             rate;

  initial begin
    for (int k = 0; k < DC; k++) begin
      hist[k] = '0;
      hist_ok[k] = 1'b0;
    end
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_chg = '0; m_press = 1'b0; m_rel = 1'b0;
    clear_obs();

    // Reset with button released and switches low.
    hold(3, 1'b1, 1'b1, 8'h00);
    chk("t1_rst_sw", 32'(switches_clean), 32'h0);
    chk("t1_rst_btn", 32'(button_clean), 32'h0);
    hold(4, 1'b0, 1'b1, 8'h00);
    chk("t1_post_sw", 32'(switches_clean), 32'h0);
    chk("t1_post_btn", 32'(button_clean), 32'h0);

    // Button press held.
    clear_obs();
    hold(8, 1'b0, 1'b0, 8'h00);
    chk("t2_rise_edge", 32'(first_btn), 32'd6);
    chk("t2_presses", 32'(presses), 32'd1);
    chk("t2_releases", 32'(releases), 32'd0);
    clear_obs();
    hold(8, 1'b0, 1'b1, 8'h00);
    chk("t2_rel_count", 32'(releases), 32'd1);

    // Short press is rejected.
    clear_obs();
    hold(3, 1'b0, 1'b0, 8'h00);
    hold(8, 1'b0, 1'b1, 8'h00);
    chk("t3_btn_seen", 32'(btn_seen), 32'd0);
    chk("t3_presses", 32'(presses), 32'd0);
    chk("t3_releases", 32'(releases), 32'd0);

    // Switches and button change at the same edge.
    clear_obs();
    hold(8, 1'b0, 1'b0, 8'hA5);
    chk("t4_btn_edge", 32'(first_btn), 32'd6);
    chk("t4_chg_edge", 32'(first_chg_edge), 32'd6);
    chk("t4_chg_val", 32'(first_chg_val), 32'hA5);
    chk("t4_presses", 32'(presses), 32'd1);
    chk("t4_sw_clean", 32'(switches_clean), 32'hA5);

    // Bounce on switch 0, final transition at edge 4.
    hold(8, 1'b0, 1'b0, 8'hA4);
    clear_obs();
    cyc(1'b0, 1'b0, 8'hA4);
    cyc(1'b0, 1'b0, 8'hA5);
    cyc(1'b0, 1'b0, 8'hA4);
    hold(8, 1'b0, 1'b0, 8'hA5);
    chk("t5_rise_edge", 32'(first_sw0), 32'd9);
    chk("t5_sw0_pulses", 32'(sw0_chg), 32'd1);

    // Reset mid-count with the button held through release.
    hold(8, 1'b0, 1'b1, 8'hA5);
    hold(4, 1'b0, 1'b0, 8'hA5);
    hold(2, 1'b1, 1'b0, 8'hA5);
    chk("t6_rst_btn", 32'(button_clean), 32'h0);
    clear_obs();
    hold(10, 1'b0, 1'b0, 8'hA5);
    chk("t6_rise_edge", 32'(first_btn), 32'd6);
    chk("t6_presses", 32'(presses), 32'd1);

    // Random bouncing inputs with occasional reset.
    r_btn = 1'b1;
    r_sw  = 8'hA5;
    for (int i = 0; i < 3000; i++) begin
      rate = (i < 1500) ? 3 : 12;
      if ($urandom_range(0, rate - 1) == 0) r_btn = ~r_btn;
      for (int b = 0; b < NSW; b++)
        if ($urandom_range(0, rate - 1) == 0) r_sw[b] = ~r_sw[b];
      cyc(($urandom_range(0, 399) == 0), r_btn, r_sw);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
